// File: rtl/pwm_dac_pkg.sv
// Shared types and sample-conditioning helpers for the PWM DAC output stage.
package pwm_dac_pkg;

  typedef enum logic [1:0] {MUTED, RAMP_UP, RUN, RAMP_DOWN} ramp_state_t;

  // Gain g out of w steps: g==w is unity, g==0 is silence.
  function automatic logic signed [31:0] scale_gain(input logic signed [31:0] s,
                                                    input int g, input int w);
    logic signed [31:0] r;
    if (g == 0) r = '0;
    else        r = s >>> (w - g);
    return r;
  endfunction

  // Signed two's-complement to offset-binary: flip the sign bit of a w-bit value.
  function automatic logic [31:0] to_offset(input logic [31:0] x, input int w);
    return x ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/pwm_dac_out_cmp.sv
// PWM period counter, period-boundary strobe and registered duty comparator.
module pwm_cmp #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] duty,
  output logic                  boundary_o,
  output logic                  pwm_o
);

  logic [DATA_WIDTH-1:0] r_cnt;
  logic                  r_pwm;

  assign boundary_o = (r_cnt == '1);
  assign pwm_o      = r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_pwm <= (r_cnt < duty);
    end
  end

endmodule

// File: rtl/pwm_dac_out.sv
// PWM DAC output stage: one-entry sample buffer applied at period boundaries,
// click-free gain ramp on mute/unmute, and a saturating overrun counter.
module pwm_dac_out
  import pwm_dac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  vld_i,
  output logic                  pwm_o,
  output logic                  active_o,
  output logic [OVR_CNT_W-1:0]  ovr_cnt_o
);

  localparam int                    GW     = $clog2(DATA_WIDTH + 1);
  localparam logic [GW-1:0]         G_FULL = GW'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MID    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] r_pend;
  logic                         r_pend_vld;
  logic signed [DATA_WIDTH-1:0] r_s_hold;
  logic [DATA_WIDTH-1:0]        r_duty;
  logic [GW-1:0]                r_g;
  ramp_state_t                  r_state;
  logic                         r_active;
  logic [OVR_CNT_W-1:0]         r_ovr;

  logic                         w_boundary;
  logic signed [DATA_WIDTH-1:0] w_s_sel;
  logic [GW-1:0]                w_g_next;
  ramp_state_t                  w_state_next;
  logic [DATA_WIDTH-1:0]        w_duty_next;

  assign w_s_sel     = r_pend_vld ? r_pend : r_s_hold;
  assign w_duty_next = DATA_WIDTH'(to_offset(scale_gain(32'(w_s_sel), 32'(w_g_next), DATA_WIDTH),
                                             DATA_WIDTH));

  // Gain moves one step per period; the state follows from where g lands.
  always_comb begin
    w_g_next     = r_g;
    w_state_next = r_state;
    unique case (r_state)
      MUTED:   if (en)  w_g_next = r_g + 1'b1;
      RUN:     if (!en) w_g_next = r_g - 1'b1;
      default: w_g_next = en ? r_g + 1'b1 : r_g - 1'b1;
    endcase
    if (w_g_next == '0)          w_state_next = MUTED;
    else if (w_g_next == G_FULL) w_state_next = RUN;
    else if (w_g_next != r_g)    w_state_next = en ? RAMP_UP : RAMP_DOWN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_s_hold   <= '0;
      r_duty     <= MID;
      r_g        <= '0;
      r_state    <= MUTED;
      r_active   <= 1'b0;
      r_ovr      <= '0;
    end else begin
      if (vld_i) begin
        r_pend     <= data_i;
        r_pend_vld <= 1'b1;
        // A sample landing on the boundary replaces one that is being consumed, not lost.
        if (r_pend_vld && !w_boundary && (r_ovr != '1))
          r_ovr <= r_ovr + 1'b1;
      end
      if (w_boundary) begin
        r_s_hold <= w_s_sel;
        r_g      <= w_g_next;
        r_state  <= w_state_next;
        r_active <= (w_state_next == RUN);
        r_duty   <= w_duty_next;
        if (!vld_i) r_pend_vld <= 1'b0;
      end
    end
  end

  pwm_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .duty      (r_duty),
    .boundary_o(w_boundary),
    .pwm_o     (pwm_o)
  );

  assign active_o  = r_active;
  assign ovr_cnt_o = r_ovr;

endmodule

// File: tb/tb_pwm_dac_out.sv
// Directed bench for pwm_dac_out at DATA_WIDTH=8 (256-cycle PWM period).
module tb_pwm_dac_out;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b0;
  logic       vld_i  = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       pwm_o;
  logic       active_o;
  logic [7:0] ovr_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  pwm_dac_out #(.DATA_WIDTH(8), .OVR_CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .data_i   (data_i),
    .vld_i    (vld_i),
    .pwm_o    (pwm_o),
    .active_o (active_o),
    .ovr_cnt_o(ovr_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full PWM period starting just after a boundary edge; returns high-cycle count.
  task automatic run_period(input int nv, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic bv, input logic [7:0] bs,
                            output int highs);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      vld_i  = 1'b0;
      data_i = 8'h00;
      if (i == 10 && nv > 0) begin vld_i = 1'b1; data_i = s0; end
      if (i == 20 && nv > 1) begin vld_i = 1'b1; data_i = s1; end
      if (i == 30 && nv > 2) begin vld_i = 1'b1; data_i = s2; end
      if (i == 255 && bv)    begin vld_i = 1'b1; data_i = bs; end
      tick();
      if (pwm_o === 1'b1) highs++;
    end
    vld_i  = 1'b0;
    data_i = 8'h00;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (pwm_o !== 1'b0) begin n_err++; $display("FAIL reset_pwm: got %b want 0", pwm_o); end
    n_cmp++; if (active_o !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", active_o); end
    n_cmp++; if (ovr_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_ovr: got %0d want 0", ovr_cnt_o); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_muted();
    int h;
    en = 1'b0;
    run_period(1, 8'd100, 8'd0, 8'd0, 1'b0, 8'd0, h);
    n_cmp++; if (h !== 128) begin n_err++; $display("FAIL muted_p0_highs: got %0d want 128", h); end
    run_period(1, 8'd100, 8'd0, 8'd0, 1'b0, 8'd0, h);
    n_cmp++; if (h !== 128) begin n_err++; $display("FAIL muted_p1_highs: got %0d want 128", h); end
    n_cmp++; if (active_o !== 1'b0) begin n_err++; $display("FAIL muted_active: got %b want 0", active_o); end
    n_cmp++; if (ovr_cnt_o !== 8'd0) begin n_err++; $display("FAIL muted_ovr: got %0d want 0", ovr_cnt_o); end
  endtask

  task automatic test_ramp_up();
    int h;
    int exp_h [9];
    exp_h = '{128, 128, 129, 130, 132, 136, 144, 160, 192};
    en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      run_period(1, 8'd64, 8'd0, 8'd0, 1'b0, 8'd0, h);
      n_cmp++;
      if (h !== exp_h[k]) begin
        n_err++; $display("FAIL ramp_up_highs[%0d]: got %0d want %0d", k, h, exp_h[k]);
      end
      if (k == 6) begin
        n_cmp++; if (active_o !== 1'b0) begin n_err++; $display("FAIL ramp_up_active_g7: got %b want 0", active_o); end
      end
      if (k == 7) begin
        n_cmp++; if (active_o !== 1'b1) begin n_err++; $display("FAIL ramp_up_active_g8: got %b want 1", active_o); end
      end
    end
  endtask

  task automatic test_extremes();
    int h;
    run_period(1, 8'h80, 8'd0, 8'd0, 1'b0, 8'd0, h);
    n_cmp++; if (h !== 192) begin n_err++; $display("FAIL ext_prev_highs: got %0d want 192", h); end
    run_period(1, 8'd127, 8'd0, 8'd0, 1'b0, 8'd0, h);
    n_cmp++; if (h !== 0) begin n_err++; $display("FAIL ext_min_highs: got %0d want 0", h); end
    run_period(0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, h);
    n_cmp++; if (h !== 255) begin n_err++; $display("FAIL ext_max_highs: got %0d want 255", h); end
    n_cmp++; if (active_o !== 1'b1) begin n_err++; $display("FAIL ext_active: got %b want 1", active_o); end
  endtask

  task automatic test_overrun();
    int h;
    run_period(3, 8'd10, 8'd20, 8'd30, 1'b0, 8'd0, h);
    n_cmp++; if (h !== 255) begin n_err++; $display("FAIL ovr_hold_highs: got %0d want 255", h); end
    n_cmp++; if (ovr_cnt_o !== 8'd2) begin n_err++; $display("FAIL ovr_count: got %0d want 2", ovr_cnt_o); end
    run_period(0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, h);
    n_cmp++; if (h !== 158) begin n_err++; $display("FAIL ovr_last_highs: got %0d want 158", h); end
  endtask

  task automatic test_back_to_back();
    int h;
    run_period(1, 8'd40, 8'd0, 8'd0, 1'b1, 8'd50, h);
    n_cmp++; if (h !== 158) begin n_err++; $display("FAIL b2b_prev_highs: got %0d want 158", h); end
    n_cmp++; if (ovr_cnt_o !== 8'd2) begin n_err++; $display("FAIL b2b_ovr_a: got %0d want 2", ovr_cnt_o); end
    run_period(0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, h);
    n_cmp++; if (h !== 168) begin n_err++; $display("FAIL b2b_first_highs: got %0d want 168", h); end
    run_period(0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, h);
    n_cmp++; if (h !== 178) begin n_err++; $display("FAIL b2b_second_highs: got %0d want 178", h); end
    n_cmp++; if (ovr_cnt_o !== 8'd2) begin n_err++; $display("FAIL b2b_ovr_b: got %0d want 2", ovr_cnt_o); end
  endtask

  task automatic test_ramp_down();
    int h;
    int exp_h [9];
    exp_h = '{178, 153, 140, 134, 131, 129, 128, 128, 128};
    en = 1'b0;
    for (int k = 0; k < 9; k++) begin
      run_period(0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, h);
      n_cmp++;
      if (h !== exp_h[k]) begin
        n_err++; $display("FAIL ramp_down_highs[%0d]: got %0d want %0d", k, h, exp_h[k]);
      end
      if (k == 0) begin
        n_cmp++; if (active_o !== 1'b0) begin n_err++; $display("FAIL ramp_down_active: got %b want 0", active_o); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int h;
    repeat (100) tick();
    n_cmp++; if (pwm_o !== 1'b1) begin n_err++; $display("FAIL mid_pre_pwm: got %b want 1", pwm_o); end
    run_period(1, 8'd77, 8'd0, 8'd0, 1'b0, 8'd0, h);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pwm_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_pwm: got %b want 0", pwm_o); end
    n_cmp++; if (ovr_cnt_o !== 8'd0) begin n_err++; $display("FAIL mid_rst_ovr: got %0d want 0", ovr_cnt_o); end
    n_cmp++; if (active_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_active: got %b want 0", active_o); end
    n_cmp++; if (dut.u_cmp.r_cnt !== 8'd0) begin n_err++; $display("FAIL mid_rst_cnt: got %0d want 0", dut.u_cmp.r_cnt); end
    n_cmp++; if (dut.r_pend_vld !== 1'b0) begin n_err++; $display("FAIL mid_rst_pend_vld: got %b want 0", dut.r_pend_vld); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_period(0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, h);
    n_cmp++; if (h !== 128) begin n_err++; $display("FAIL mid_post_highs: got %0d want 128", h); end
  endtask

  initial begin
    test_reset();
    test_muted();
    test_ramp_up();
    test_extremes();
    test_overrun();
    test_back_to_back();
    test_ramp_down();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
